// File: rtl/forwarding_scoreboard_pkg.sv
// forwarding_pkg: shared entry type, widths and data-ready helper for the forwarding scoreboard
package forwarding_pkg;
  localparam int MAX_REG_W = 16;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic                 load;
    logic [MAX_REG_W-1:0] rd;
  } sb_entry_t;
  function automatic logic data_ready(int k, logic load, int load_stage);
    return !load || k >= load_stage;
  endfunction
endpackage

// File: rtl/forwarding_scoreboard_if.sv
// forwarding_scoreboard_if: issue, operand and pipeline-control bundle; master drives issue/operands, slave resolves
interface forwarding_scoreboard_if
  import forwarding_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int NSTAGES = 3,
  parameter int NREAD   = 2
);
  localparam int SEL_W = $clog2(NSTAGES + 1);
  logic                      issue_valid;
  logic                      issue_wen;
  logic                      issue_load;
  logic [REG_W-1:0]          issue_rd;
  logic [NREAD-1:0]          rs_en;
  logic [NREAD*REG_W-1:0]    rs_addr;
  logic [NREAD*DATA_W-1:0]   rf_data;
  logic [NSTAGES*DATA_W-1:0] stage_data;
  logic                      advance;
  logic                      flush;
  logic [NREAD*SEL_W-1:0]    fwd_sel;
  logic [NREAD*DATA_W-1:0]   opnd_data;
  logic                      stall;
  logic                      issue_accept;
  logic [CNT_W-1:0]          stall_cycles;
  modport master (
    output issue_valid, issue_wen, issue_load, issue_rd, rs_en, rs_addr, rf_data, stage_data, advance, flush,
    input  fwd_sel, opnd_data, stall, issue_accept, stall_cycles
  );
  modport slave (
    input  issue_valid, issue_wen, issue_load, issue_rd, rs_en, rs_addr, rf_data, stage_data, advance, flush,
    output fwd_sel, opnd_data, stall, issue_accept, stall_cycles
  );
endinterface

// File: rtl/forwarding_scoreboard_lookup.sv
// fwd_lookup: youngest-live-producer match for one source operand
// ports: ent_i entry array (index 0 = stage 1), en_i/addr_i operand, sel_o stage or 0, hit_o match, ready_o data valid
module fwd_lookup
  import forwarding_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(NSTAGES + 1)
) (
  input  sb_entry_t [NSTAGES-1:0] ent_i,
  input  logic                    en_i,
  input  logic [REG_W-1:0]        addr_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    hit_o,
  output logic                    ready_o
);
  // walk oldest to youngest so the lowest matching stage wins
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    ready_o = 1'b1;
    for (int k = NSTAGES; k >= 1; k--)
      if (en_i && ent_i[k-1].valid && ent_i[k-1].wen && ent_i[k-1].rd != '0 &&
          ent_i[k-1].rd == MAX_REG_W'(addr_i)) begin
        sel_o = SEL_W'(k);
        hit_o = 1'b1;
        ready_o = data_ready(k, ent_i[k-1].load, LOAD_STAGE);
      end
  end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: tracks in-flight destinations, forwards operands, raises load-use stall, counts stalls
// ports: CLK, RST (async, active-high), bus (slave side of forwarding_scoreboard_if)
module forwarding_scoreboard
  import forwarding_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int NSTAGES    = 3,
  parameter int NREAD      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(NSTAGES + 1)
) (
  input logic CLK,
  input logic RST,
  forwarding_scoreboard_if.slave bus
);
  sb_entry_t [NSTAGES-1:0] ent_q, ent_d;
  sb_entry_t               iss;
  logic [NREAD-1:0]        hit, ready;
  logic [NREAD*SEL_W-1:0]  sel;
  logic                    stall;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  for (genvar i = 0; i < NREAD; i++) begin : g_port
    fwd_lookup #(.NSTAGES(NSTAGES), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_lookup (
      .ent_i  (ent_q),
      .en_i   (bus.rs_en[i]),
      .addr_i (bus.rs_addr[i*REG_W +: REG_W]),
      .sel_o  (sel[i*SEL_W +: SEL_W]),
      .hit_o  (hit[i]),
      .ready_o(ready[i])
    );
  end
  assign stall = |(hit & ~ready);
  assign bus.stall = stall;
  assign bus.fwd_sel = sel;
  assign bus.issue_accept = bus.issue_valid && bus.advance && !stall && !bus.flush;
  assign bus.stall_cycles = cnt_q;
  always_comb begin
    bus.opnd_data = bus.rf_data;
    for (int i = 0; i < NREAD; i++)
      for (int k = 1; k <= NSTAGES; k++)
        if (sel[i*SEL_W +: SEL_W] == SEL_W'(k))
          bus.opnd_data[i*DATA_W +: DATA_W] = bus.stage_data[(k-1)*DATA_W +: DATA_W];
  end
  always_comb begin
    iss = '0;
    if (!stall)
      iss = '{valid: bus.issue_valid, wen: bus.issue_wen, load: bus.issue_load, rd: MAX_REG_W'(bus.issue_rd)};
    ent_d = ent_q;
    if (bus.flush)
      ent_d = '0;
    else if (bus.advance)
      ent_d = {ent_q[NSTAGES-2:0], iss};
    cnt_d = (stall && bus.advance && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
endmodule
